// File: rtl/rs_pkg.sv
// rs_pkg: shared Reed-Solomon constants for the CIRC encoder and decoder.
//   RS_POLY   field polynomial x^8+x^4+x^3+x^2+1 over GF(2^8), alpha = 0x02
//   RS_NPAR   number of parity symbols per codeword
//   RS_G3..0  coefficients of g(x) = (x+1)(x+a)(x+a^2)(x+a^3), monic term implied
//   rs_state_e  encoder sequencing states
//   gf_mul    general GF(2^8) multiply; folds to an XOR network when one
//             operand is a constant
package rs_pkg;

   localparam logic [8:0] RS_POLY = 9'h11D;
   localparam int         RS_NPAR = 4;

   localparam logic [7:0] RS_G3 = 8'h0F;
   localparam logic [7:0] RS_G2 = 8'h36;
   localparam logic [7:0] RS_G1 = 8'h78;
   localparam logic [7:0] RS_G0 = 8'h40;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } rs_state_e;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         // multiply x by alpha, reducing modulo the field polynomial
         x = {x[6:0], 1'b0} ^ (x[7] ? RS_POLY[7:0] : 8'h00);
      end
      return p;
   endfunction

endpackage

// File: rtl/gf_mul_const.sv
// gf_mul_const: combinational multiply of a GF(2^8) symbol by constant C.
//   a_i  in   8  symbol
//   y_o  out  8  a_i * C in GF(2^8)
module gf_mul_const
   import rs_pkg::*;
#(
   parameter logic [7:0] C = 8'h01
) (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   assign y_o = gf_mul(a_i, C);

endmodule

// File: rtl/rs_enc_lfsr.sv
// rs_enc_lfsr: byte-serial systematic RS encoder, 4 parity symbols per codeword.
// Message bytes pass through with one cycle of latency, then p3,p2,p1,p0 follow.
//   i_clk       in   1  clock, rising edge
//   i_resb      in   1  asynchronous active-low reset
//   i_valid     in   1  input byte valid
//   i_first     in   1  first byte of a message (qualified by i_valid)
//   i_data      in   8  message byte
//   o_in_ready  out  1  encoder accepts a byte this cycle (low while emitting parity)
//   o_valid     out  1  output byte valid
//   o_first     out  1  first byte of the output codeword
//   o_last      out  1  last parity byte (p0)
//   o_data      out  8  codeword byte
module rs_enc_lfsr
   import rs_pkg::*;
#(
   parameter int K = 28
) (
   input  logic       i_clk,
   input  logic       i_resb,
   input  logic       i_valid,
   input  logic       i_first,
   input  logic [7:0] i_data,
   output logic       o_in_ready,
   output logic       o_valid,
   output logic       o_first,
   output logic       o_last,
   output logic [7:0] o_data
);

   localparam int CW = $clog2(K + 1);
   localparam logic [3:0][7:0] GEN = {RS_G3, RS_G2, RS_G1, RS_G0};

   rs_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_nxt;
   logic [1:0]      pcnt_q, pcnt_d;
   logic [3:0][7:0] r_q, r_d, r_base, fb_mul;
   logic [7:0]      fb;
   logic            accept, restart;
   logic            valid_q, valid_d, first_q, first_d, last_q, last_d;
   logic [7:0]      data_q, data_d;

   assign o_in_ready = (state_q != PARITY);
   assign accept     = i_valid & o_in_ready;

   // A first-flagged byte (or any byte leaving IDLE) starts from an empty
   // remainder, which is also how an in-flight message is abandoned.
   assign restart = i_first | (state_q == IDLE);
   assign r_base  = restart ? '0 : r_q;
   assign fb      = i_data ^ r_base[3];
   assign cnt_nxt = restart ? CW'(1) : cnt_q + CW'(1);

   for (genvar g = 0; g < 4; g++) begin : g_mul
      gf_mul_const #(.C(GEN[g])) u_mul (
         .a_i (fb),
         .y_o (fb_mul[g])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      r_d     = r_q;
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      data_d  = 8'h00;
      unique case (state_q)
         IDLE, DATA: begin
            // in IDLE a byte without i_first is consumed and discarded
            if (accept && (state_q == DATA || i_first)) begin
               r_d     = {r_base[2] ^ fb_mul[3], r_base[1] ^ fb_mul[2],
                          r_base[0] ^ fb_mul[1], fb_mul[0]};
               cnt_d   = cnt_nxt;
               valid_d = 1'b1;
               first_d = i_first;
               data_d  = i_data;
               if (cnt_nxt == CW'(K)) begin
                  state_d = PARITY;
                  pcnt_d  = 2'd0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         PARITY: begin
            valid_d = 1'b1;
            data_d  = r_q[3];
            r_d     = {r_q[2:0], 8'h00};
            pcnt_d  = pcnt_q + 2'd1;
            if (pcnt_q == 2'(RS_NPAR - 1)) begin
               last_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resb) begin
      if (!i_resb) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pcnt_q  <= 2'd0;
         r_q     <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         r_q     <= r_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end

   assign o_valid = valid_q;
   assign o_first = first_q;
   assign o_last  = last_q;
   assign o_data  = data_q;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// tb_rs_enc_lfsr: randomized self-checking bench for rs_enc_lfsr (K=28).
// Expected codewords come from polynomial long division by g(x) and are
// cross-checked with syndrome evaluation at alpha^0..alpha^3.
module tb_rs_enc_lfsr;

   localparam int K  = 28;
   localparam int NW = K + 4;

   logic       i_clk = 1'b0;
   logic       i_resb;
   logic       i_valid, i_first;
   logic [7:0] i_data;
   logic       o_in_ready, o_valid, o_first, o_last;
   logic [7:0] o_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rdy_low = 0;

   logic [7:0] msg [0:K-1];
   logic [7:0] tx_d[$];
   logic       tx_f[$];
   logic [7:0] exp_d[$], out_d[$];
   logic       exp_f[$], exp_l[$], out_f[$], out_l[$];
   int         out_c[$];

   rs_enc_lfsr #(.K(K)) dut (
      .i_clk      (i_clk),
      .i_resb     (i_resb),
      .i_valid    (i_valid),
      .i_first    (i_first),
      .i_data     (i_data),
      .o_in_ready (o_in_ready),
      .o_valid    (o_valid),
      .o_first    (o_first),
      .o_last     (o_last),
      .o_data     (o_data)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (i_resb) begin
         if (o_valid) begin
            out_d.push_back(o_data);
            out_f.push_back(o_first);
            out_l.push_back(o_last);
            out_c.push_back(cyc);
         end
         if (!o_in_ready) rdy_low++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      end
      return p;
   endfunction

   // remainder of msg(x)*x^4 divided by g(x), returned as {p3,p2,p1,p0}
   function automatic logic [31:0] model_parity();
      logic [7:0] rem [0:K+3];
      logic [7:0] g [0:4];
      logic [7:0] c;
      g[0] = 8'h01; g[1] = 8'h0F; g[2] = 8'h36; g[3] = 8'h78; g[4] = 8'h40;
      for (int i = 0; i < K; i++) rem[i] = msg[i];
      for (int i = 0; i < 4; i++) rem[K+i] = 8'h00;
      for (int i = 0; i < K; i++) begin
         c = rem[i];
         for (int j = 1; j <= 4; j++) rem[i+j] = rem[i+j] ^ gmul(c, g[j]);
      end
      return {rem[K], rem[K+1], rem[K+2], rem[K+3]};
   endfunction

   function automatic void push_cw();
      logic [31:0] p;
      p = model_parity();
      for (int i = 0; i < K; i++) begin
         exp_d.push_back(msg[i]); exp_f.push_back(i == 0); exp_l.push_back(1'b0);
      end
      for (int j = 0; j < 4; j++) begin
         exp_d.push_back(p[31-8*j -: 8]); exp_f.push_back(1'b0); exp_l.push_back(j == 3);
      end
   endfunction

   function automatic void add_tx();
      for (int i = 0; i < K; i++) begin
         tx_d.push_back(msg[i]); tx_f.push_back(i == 0);
      end
   endfunction

   function automatic void rand_msg();
      for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(255));
   endfunction

   function automatic void clear_all();
      exp_d.delete(); exp_f.delete(); exp_l.delete();
      out_d.delete(); out_f.delete(); out_l.delete(); out_c.delete();
      tx_d.delete(); tx_f.delete();
   endfunction

   // ---------------- stimulus ----------------
   // Entered and left just after a rising edge.
   task automatic drive(input int gap_pct);
      int guard;
      guard = 0;
      while (tx_d.size() > 0 && guard < 20000) begin
         i_valid = (int'($urandom_range(99)) >= gap_pct) && o_in_ready;
         i_first = tx_f[0];
         i_data  = tx_d[0];
         @(posedge i_clk); #1;
         if (i_valid) begin
            void'(tx_d.pop_front());
            void'(tx_f.pop_front());
         end
         guard++;
      end
      i_valid = 1'b0;
      i_first = 1'b0;
      checks++;
      if (tx_d.size() != 0) begin
         errors++;
         $display("FAIL drive_budget: %0d bytes left unsent, want 0", tx_d.size());
      end
   endtask

   task automatic drain(input int n, input int budget);
      int t;
      t = 0;
      while (out_d.size() < n && t < budget) begin
         @(posedge i_clk); #1;
         t++;
      end
      repeat (3) @(posedge i_clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      i_resb = 1'b0; i_valid = 1'b0; i_first = 1'b0; i_data = 8'h00;
      #12;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
      checks++; if (o_first !== 1'b0) begin errors++; $display("FAIL rst_first: got %b want 0", o_first); end
      checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", o_last); end
      checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", o_data); end
      checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", o_in_ready); end
      #5 i_resb = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_zero();
      clear_all();
      for (int i = 0; i < K; i++) msg[i] = 8'h00;
      add_tx(); push_cw();
      drive(0); drain(NW, 50);
      checks++;
      if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL zero_len: got %0d bytes want %0d", out_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL zero_byte%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL zero_byte%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_impulse();
      logic [7:0] lit [0:3];
      lit[0] = 8'h0F; lit[1] = 8'h36; lit[2] = 8'h78; lit[3] = 8'h40;
      clear_all();
      // stray byte without i_first while idle must vanish
      tx_d.push_back(8'hAA); tx_f.push_back(1'b0);
      for (int i = 0; i < K; i++) msg[i] = 8'h00;
      msg[K-1] = 8'h01;
      add_tx(); push_cw();
      drive(0); drain(NW, 50);
      checks++;
      if (out_d.size() != NW) begin errors++; $display("FAIL imp_len: got %0d bytes want %0d", out_d.size(), NW); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL imp_byte%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL imp_byte%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (K + j >= out_d.size() || out_d[K+j] !== lit[j]) begin
            errors++; $display("FAIL imp_parity%0d: got %h want %h", j,
                               (K + j < out_d.size()) ? out_d[K+j] : 8'hXX, lit[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] s, a;
      logic [7:0] pw [0:3];
      int base;
      logic ok;
      pw[0] = 8'h01; pw[1] = 8'h02; pw[2] = 8'h04; pw[3] = 8'h08;
      clear_all();
      for (int c = 0; c < 100; c++) begin
         rand_msg(); add_tx(); push_cw();
      end
      rdy_low = 0;
      drive(0); drain(100 * NW, 200);
      checks++;
      if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL b2b_len: got %0d bytes want %0d", out_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL b2b_byte%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL b2b_byte%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
      for (int c = 0; c < 100; c++) begin
         base = c * NW;
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_d.size() < base + NW) begin
               errors++; $display("FAIL b2b_syn cw%0d s%0d: codeword incomplete, want 00", c, j);
            end else begin
               s = 8'h00; a = pw[j];
               for (int k = 0; k < NW; k++) s = gmul(s, a) ^ out_d[base+k];
               if (s !== 8'h00) begin errors++; $display("FAIL b2b_syn cw%0d s%0d: got %h want 00", c, j, s); end
            end
         end
      end
      ok = (out_c.size() > 0);
      for (int i = 0; i < out_c.size(); i++) if (out_c[i] != out_c[0] + i) ok = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_gapless: got gaps in %0d output bytes, want none", out_c.size()); end
      checks++;
      if (rdy_low != 400) begin errors++; $display("FAIL b2b_ready_low: got %0d cycles want 400", rdy_low); end
   endtask

   task automatic test_gaps();
      logic [7:0] gp [0:3];
      clear_all();
      rand_msg(); add_tx(); push_cw();
      drive(50); drain(NW, 100);
      checks++;
      if (out_d.size() != NW) begin errors++; $display("FAIL gap_len: got %0d bytes want %0d", out_d.size(), NW); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL gap_byte%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL gap_byte%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
      for (int j = 0; j < 4; j++) gp[j] = (K + j < out_d.size()) ? out_d[K+j] : 8'hXX;
      // same message again without stalls: parity must not depend on gaps
      clear_all();
      add_tx();
      drive(0); drain(NW, 50);
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (K + j >= out_d.size() || out_d[K+j] !== gp[j]) begin
            errors++; $display("FAIL gap_vs_gapless p%0d: gapless %h gapped %h",
                               3 - j, (K + j < out_d.size()) ? out_d[K+j] : 8'hXX, gp[j]);
         end
      end
   endtask

   task automatic test_abort();
      clear_all();
      rand_msg();
      for (int i = 0; i < 9; i++) begin
         tx_d.push_back(msg[i]); tx_f.push_back(i == 0);
         exp_d.push_back(msg[i]); exp_f.push_back(i == 0); exp_l.push_back(1'b0);
      end
      rand_msg(); add_tx(); push_cw();
      drive(20); drain(9 + NW, 100);
      checks++;
      if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL abort_len: got %0d bytes want %0d", out_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL abort_byte%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL abort_byte%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset_parity();
      logic [7:0] p2;
      clear_all();
      rand_msg(); add_tx(); push_cw();
      p2 = exp_d[K+1];
      // only the message and p3 get out before the reset lands
      repeat (3) begin
         void'(exp_d.pop_back()); void'(exp_f.pop_back()); void'(exp_l.pop_back());
      end
      drive(0);
      @(posedge i_clk);
      @(posedge i_clk);
      #2;
      checks++;
      if (o_valid !== 1'b1 || o_data !== p2) begin
         errors++; $display("FAIL rstp_p2: got v=%b d=%h want v=1 d=%h", o_valid, o_data, p2);
      end
      #1 i_resb = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_first, o_last, o_data} !== 11'h0) begin
         errors++; $display("FAIL rstp_async: got v=%b f=%b l=%b d=%h want all 0", o_valid, o_first, o_last, o_data);
      end
      checks++;
      if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready: got %b want 1", o_in_ready); end
      #3 i_resb = 1'b1;
      @(posedge i_clk); #1;
      repeat (6) @(posedge i_clk);
      #1;
      checks++;
      if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL rstp_len: got %0d bytes want %0d", out_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL rstp_byte%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL rstp_byte%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
      // fresh message after reset encodes from a clean remainder
      clear_all();
      rand_msg(); add_tx(); push_cw();
      drive(0); drain(NW, 50);
      checks++;
      if (out_d.size() != NW) begin errors++; $display("FAIL rstp_next_len: got %0d bytes want %0d", out_d.size(), NW); end
      for (int i = 0; i < exp_d.size(); i++) begin
         checks++;
         if (i >= out_d.size()) begin errors++; $display("FAIL rstp_next%0d: missing, want %h", i, exp_d[i]); end
         else if ({out_f[i], out_l[i], out_d[i]} !== {exp_f[i], exp_l[i], exp_d[i]}) begin
            errors++; $display("FAIL rstp_next%0d: got f=%b l=%b d=%h want f=%b l=%b d=%h",
                               i, out_f[i], out_l[i], out_d[i], exp_f[i], exp_l[i], exp_d[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_impulse();
      test_back_to_back();
      test_gaps();
      test_abort();
      test_reset_parity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rs_enc_lfsr.md
# rs_enc_lfsr

Systematic Reed-Solomon encoder over GF(2^8) producing 4 parity symbols per codeword. It is the transmit-side counterpart of the decoder's syndrome/Euclid path: its codewords must yield all-zero syndromes s0..s3 at the decoder. Byte-serial: K message bytes pass through with 1-cycle latency, then 4 parity bytes are appended. Used for CIRC C1/C2 stimulus generation and loopback self-test.

## Interface

Parameters:
- K, 28, message length in bytes (valid range 1..251).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_resb  in  1  reset; asynchronous, active-low.
- i_valid  in  1  input byte valid.
- i_first  in  1  qualifies the first byte of a message (sampled only with i_valid).
- i_data  in  8  message byte.
- o_in_ready  out  1  encoder accepts a byte this cycle.
- o_valid  out  1  output byte valid.
- o_first  out  1  first byte of output codeword.
- o_last  out  1  last parity byte (p0).
- o_data  out  8  codeword byte.

## Operation

- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02.
- Generator g(x) = ∏(x+α^i), i=0..3 = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.
- Parity register r3..r0, 8 bits each. On an accepted byte d: fb = d ^ r3; r3 ← r2 ^ fb·0x0F; r2 ← r1 ^ fb·0x36; r1 ← r0 ^ fb·0x78; r0 ← fb·0x40. Constant GF multiplies are pure XOR networks.
- Accept = i_valid & o_in_ready.
- States:
  - IDLE: o_in_ready=1; accept with i_first=1 → load r from fb with prior r = 0, cnt=1, → DATA (or → PARITY if K=1). Accept with i_first=0 is dropped, with no output.
  - DATA: o_in_ready=1; each accept updates r and cnt++. An accept with i_first=1 aborts the current message: clear r, treat the byte as byte 1, and no parity is emitted for the aborted message. Accept making cnt==K → PARITY, pcnt=0.
  - PARITY: o_in_ready=0; each cycle emit r3 and shift r3←r2, r2←r1, r1←r0, r0←0. pcnt==3 → IDLE.
- Output order: message bytes in input order, then p3, p2, p1, p0. The codeword polynomial has the first byte as the highest degree.
- o_first=1 with the output of an accepted byte that had i_first=1. o_last=1 with p0 only.
- cnt width is clog2(K+1). pcnt is 2 bits. No wrap beyond K: the transition fires at equality.

## Timing

- Reset values: o_valid=0, o_first=0, o_last=0, o_data=0x00, r3..r0=0, state IDLE, cnt=0, pcnt=0. o_in_ready=1 (combinational from state).
- All outputs except o_in_ready are registered. A byte accepted at edge n appears on o_data after edge n, valid for 1 cycle.
- K-th byte accepted at edge n: parity bytes appear after edges n+1..n+4. o_in_ready is low after edges n..n+3 and high again after edge n+4.
- The next message's first byte can be accepted at edge n+5. Continuous input therefore gives gapless output of K+4 bytes per K+4 cycles.
- o_valid=0 in any cycle with no accept and not in PARITY.
- i_valid gaps in DATA stall the encoder without state loss.
- Reset asserted mid-message or mid-parity: everything clears immediately. A partial codeword is never completed.

## Structure

- Shared package rs_pkg: RS_POLY=0x11D, RS_NPAR=4, generator coefficients G3..G0, and the state enum (IDLE/DATA/PARITY). The decoder side reuses the same constants.
- One sub-module: gf_mul_const (parameter C, 8-bit in/out, combinational), instantiated 4×.

## Test plan

- K=28, all-zero message → 32 output bytes all 0x00; o_first on byte 1, o_last on byte 32.
- K=28, 27×0x00 then 0x01 → parity 0x0F, 0x36, 0x78, 0x40. This checks the generator coefficients and the output order.
- K=28, random message stream of 100 back-to-back codewords → the bench GF model's syndromes s0..s3 are all 0x00 for every codeword; no output gaps; o_in_ready is low exactly 4 cycles per codeword.
- Random i_valid deasserts (50%) during DATA → parity is identical to the gapless run of the same message.
- i_first re-asserted at byte 10 of a message → the aborted message emits no parity; the new codeword's parity matches the model starting from that byte.
- Reset pulsed during the 2nd parity byte → outputs return to 0 asynchronously; the next message encodes correctly from a clean state.
